// File: rtl/multicycle_main_ctrl_if.sv
// multicycle_main_ctrl_if: control bundle between the multi-cycle MIPS main FSM and its datapath.
//   slave  (controller side): takes op, zero, mem_ready; drives strobes, enables, selects and state.
//   master (datapath side)  : drives op, zero, mem_ready; takes everything else.
interface multicycle_main_ctrl_if;
   logic [5:0] op;
   logic       zero;
   logic       mem_ready;
   logic       mem_read;
   logic       mem_write;
   logic       iord;
   logic       ir_write;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       reg_write;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic [1:0] pc_source;
   logic       pc_en;
   logic [3:0] state;
   modport slave (
      input  op, zero, mem_ready,
      output mem_read, mem_write, iord, ir_write, reg_dst, mem_to_reg, reg_write,
             alu_src_a, alu_src_b, alu_op, pc_source, pc_en, state
   );
   modport master (
      output op, zero, mem_ready,
      input  mem_read, mem_write, iord, ir_write, reg_dst, mem_to_reg, reg_write,
             alu_src_a, alu_src_b, alu_op, pc_source, pc_en, state
   );
endinterface

// File: rtl/multicycle_main_ctrl.sv
// multicycle_main_ctrl: main control FSM of the multi-cycle MIPS datapath.
//   clk   : rising-edge clock
//   reset : synchronous active-high, returns the FSM to FETCH
//   bus   : slave side of multicycle_main_ctrl_if (opcode, zero flag, memory handshake in;
//           memory strobes, register/PC enables, mux selects, ALUOp and debug state out)
module multicycle_main_ctrl #(
   parameter bit WAIT_MEM = 1'b1
) (
   input logic                   clk,
   input logic                   reset,
   multicycle_main_ctrl_if.slave bus
);
   typedef enum logic [3:0] {
      FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
      MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
      BRANCH = 4'd8,  ADDIEX = 4'd9,  IMMWB  = 4'd10, JUMP   = 4'd11,
      ANDIEX = 4'd12
   } state_t;

   localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                          OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000,
                          OP_ANDI = 6'b001100;

   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic       iord;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       fetch;
      logic       branch;
      logic       pc_write;
   } ctl_t;

   state_t st;
   ctl_t   c;
   logic   rdy;
   state_t nxt;

   assign rdy = WAIT_MEM ? bus.mem_ready : 1'b1;

   function automatic state_t next_st(state_t s, logic [5:0] op, logic r);
      state_t n;
      n = FETCH;
      case (s)
         FETCH:  n = r ? DECODE : FETCH;
         DECODE: case (op)
                    OP_LW, OP_SW: n = MEMADR;
                    OP_R:         n = EXEC;
                    OP_BEQ:       n = BRANCH;
                    OP_ADDI:      n = ADDIEX;
                    OP_ANDI:      n = ANDIEX;
                    OP_J:         n = JUMP;
                    default:      n = FETCH;
                 endcase
         MEMADR: n = (op == OP_SW) ? MEMWR : MEMRD;
         MEMRD:  n = r ? MEMWB : MEMRD;
         MEMWR:  n = r ? FETCH : MEMWR;
         EXEC:   n = ALUWB;
         ADDIEX: n = IMMWB;
         ANDIEX: n = IMMWB;
         default: n = FETCH;
      endcase
      return n;
   endfunction

   // Moore outputs of a state; fetch/branch/pc_write are qualifiers that get
   // combined with MemReady/Zero at the outputs.
   function automatic ctl_t dec(state_t s);
      ctl_t o;
      o = '0;
      case (s)
         FETCH:  begin o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.fetch = 1'b1; end
         DECODE: o.alu_src_b = 2'b11;
         MEMADR: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
         MEMRD:  begin o.iord = 1'b1; o.mem_read = 1'b1; end
         MEMWB:  begin o.mem_to_reg = 1'b1; o.reg_write = 1'b1; end
         MEMWR:  begin o.iord = 1'b1; o.mem_write = 1'b1; end
         EXEC:   begin o.alu_src_a = 1'b1; o.alu_op = 2'b10; end
         ALUWB:  begin o.reg_dst = 1'b1; o.reg_write = 1'b1; end
         BRANCH: begin o.alu_src_a = 1'b1; o.alu_op = 2'b01; o.pc_source = 2'b01; o.branch = 1'b1; end
         ADDIEX: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
         IMMWB:  o.reg_write = 1'b1;
         JUMP:   begin o.pc_source = 2'b10; o.pc_write = 1'b1; end
         ANDIEX: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_op = 2'b11; end
         default: o = '0;
      endcase
      return o;
   endfunction

   assign nxt = next_st(st, bus.op, rdy);

   // Outputs are registered alongside the state by decoding the state being entered.
   always_ff @(posedge clk) begin
      if (reset) begin
         st <= FETCH;
         c  <= dec(FETCH);
      end else begin
         st <= nxt;
         c  <= dec(nxt);
      end
   end

   assign bus.mem_read   = c.mem_read;
   assign bus.mem_write  = c.mem_write;
   assign bus.iord       = c.iord;
   assign bus.ir_write   = c.fetch & rdy;
   assign bus.reg_dst    = c.reg_dst;
   assign bus.mem_to_reg = c.mem_to_reg;
   assign bus.reg_write  = c.reg_write;
   assign bus.alu_src_a  = c.alu_src_a;
   assign bus.alu_src_b  = c.alu_src_b;
   assign bus.alu_op     = c.alu_op;
   assign bus.pc_source  = c.pc_source;
   assign bus.pc_en      = c.pc_write | (c.branch & bus.zero) | (c.fetch & rdy);
   assign bus.state      = st;
endmodule

// File: tb/tb_multicycle_main_ctrl.sv
// tb_multicycle_main_ctrl: directed self-checking bench for multicycle_main_ctrl.
//   The driver expands each instruction into the state trace implied by its class and
//   the chosen MemReady waits; a compare process checks every output each cycle.
module tb_multicycle_main_ctrl;
   logic clk = 1'b0;
   logic reset;
   multicycle_main_ctrl_if bus ();

   multicycle_main_ctrl #(.WAIT_MEM(1'b1)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   logic       chk = 1'b0;
   logic [3:0] exp_st;
   logic [14:0] obs;
   logic [14:0] seen [16];
   int mw_cnt;

   // {mem_read, mem_write, iord, ir_write, reg_dst, mem_to_reg, reg_write,
   //  alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_source[1:0], pc_en}
   assign obs = {bus.mem_read, bus.mem_write, bus.iord, bus.ir_write, bus.reg_dst,
                 bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                 bus.alu_op, bus.pc_source, bus.pc_en};

   function automatic logic [14:0] model(input logic [3:0] s, input logic mr, input logic z);
      case (s)
         4'd0:  return {3'b100, mr, 3'b000, 7'b0_01_00_00, mr};
         4'd1:  return {7'b0000000, 8'b0_11_00_00_0};
         4'd2:  return {7'b0000000, 8'b1_10_00_00_0};
         4'd3:  return {7'b1010000, 8'b0_00_00_00_0};
         4'd4:  return {7'b0000011, 8'b0_00_00_00_0};
         4'd5:  return {7'b0110000, 8'b0_00_00_00_0};
         4'd6:  return {7'b0000000, 8'b1_00_10_00_0};
         4'd7:  return {7'b0000101, 8'b0_00_00_00_0};
         4'd8:  return {7'b0000000, 7'b1_00_01_01, z};
         4'd9:  return {7'b0000000, 8'b1_10_00_00_0};
         4'd10: return {7'b0000001, 8'b0_00_00_00_0};
         4'd11: return {7'b0000000, 8'b0_00_00_10_1};
         4'd12: return {7'b0000000, 8'b1_10_11_00_0};
         default: return 15'd0;
      endcase
   endfunction

   task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", n, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk) begin
         check("state", 32'(bus.state), 32'(exp_st));
         check("outputs", 32'(obs), 32'(model(exp_st, bus.mem_ready, bus.zero)));
         check("rd_wr_excl", 32'(bus.mem_read & bus.mem_write), 32'd0);
         check("rw_pcen_excl", 32'(bus.reg_write & bus.pc_en), 32'd0);
      end
   end

   task automatic step(input int s, input logic [5:0] op, input logic mr, input logic z, input logic rs);
      @(posedge clk);
      #1;
      reset = rs;
      bus.op = op;
      bus.mem_ready = mr;
      bus.zero = z;
      exp_st = 4'(s);
      chk = 1'b1;
      @(negedge clk);
      #1;
      seen[bus.state] = obs;
      if (bus.mem_write) mw_cnt++;
   endtask

   function automatic logic rb();
      return 1'($urandom_range(1));
   endfunction

   task automatic run(input logic [5:0] op, input int fw, input int mw, input logic z);
      repeat (fw) step(0, op, 1'b0, rb(), 1'b0);
      step(0, op, 1'b1, rb(), 1'b0);
      step(1, op, rb(), rb(), 1'b0);
      case (op)
         6'b100011: begin
            step(2, op, rb(), rb(), 1'b0);
            repeat (mw) step(3, op, 1'b0, rb(), 1'b0);
            step(3, op, 1'b1, rb(), 1'b0);
            step(4, op, rb(), rb(), 1'b0);
         end
         6'b101011: begin
            step(2, op, rb(), rb(), 1'b0);
            repeat (mw) step(5, op, 1'b0, rb(), 1'b0);
            step(5, op, 1'b1, rb(), 1'b0);
         end
         6'b000000: begin step(6, op, rb(), rb(), 1'b0); step(7, op, rb(), rb(), 1'b0); end
         6'b001000: begin step(9, op, rb(), rb(), 1'b0); step(10, op, rb(), rb(), 1'b0); end
         6'b001100: begin step(12, op, rb(), rb(), 1'b0); step(10, op, rb(), rb(), 1'b0); end
         6'b000100: step(8, op, rb(), z, 1'b0);
         6'b000010: step(11, op, rb(), rb(), 1'b0);
         default: ;
      endcase
   endtask

   initial begin
      reset = 1'b1;
      bus.op = 6'd0;
      bus.mem_ready = 1'b0;
      bus.zero = 1'b0;
      exp_st = 4'd0;
      mw_cnt = 0;
      repeat (2) @(posedge clk);
      run(6'b100011, 0, 0, 1'b0);
      check("lw_wb", 32'({seen[4][9], seen[4][8], seen[4][4:3]}), 32'b1100);
      check("lw_adr_aluop", 32'(seen[2][4:3]), 32'b00);
      mw_cnt = 0;
      run(6'b101011, 1, 3, 1'b0);
      check("sw_memwrite_cycles", 32'(mw_cnt), 32'd4);
      run(6'b000100, 0, 0, 1'b1);
      check("beq_taken", 32'({seen[8][0], seen[8][4:3], seen[8][2:1]}), 32'b1_01_01);
      run(6'b000100, 2, 0, 1'b0);
      check("beq_not_taken", 32'(seen[8][0]), 32'd0);
      run(6'b000000, 0, 0, 1'b0);
      run(6'b001100, 0, 0, 1'b0);
      check("andi_aluop", 32'(seen[12][4:3]), 32'b11);
      check("andi_regdst", 32'(seen[10][10]), 32'd0);
      run(6'b001000, 0, 0, 1'b0);
      check("r_aluop", 32'(seen[6][4:3]), 32'b10);
      check("r_regdst", 32'(seen[7][10]), 32'd1);
      check("addi_aluop", 32'(seen[9][4:3]), 32'b00);
      run(6'b111111, 0, 0, 1'b0);
      check("illegal_decode", 32'({seen[1][13], seen[1][8], seen[1][0]}), 32'd0);
      run(6'b000010, 0, 0, 1'b0);
      check("jump", 32'({seen[11][2:1], seen[11][0]}), 32'b10_1);
      // reset held two cycles while in EXEC
      step(0, 6'b000000, 1'b1, 1'b0, 1'b0);
      step(1, 6'b000000, 1'b0, 1'b0, 1'b0);
      step(6, 6'b000000, 1'b0, 1'b0, 1'b1);
      step(0, 6'b000000, 1'b1, 1'b0, 1'b1);
      step(0, 6'b000000, 1'b0, 1'b0, 1'b0);
      check("rst_state", 32'(bus.state), 32'd0);
      check("rst_outs", 32'({bus.mem_read, bus.iord, bus.alu_src_b, bus.reg_write, bus.mem_write}), 32'b1_0_01_0_0);
      // reset during a MEMWR wait
      step(0, 6'b101011, 1'b1, 1'b0, 1'b0);
      step(1, 6'b101011, 1'b0, 1'b0, 1'b0);
      step(2, 6'b101011, 1'b0, 1'b0, 1'b0);
      step(5, 6'b101011, 1'b0, 1'b0, 1'b0);
      step(5, 6'b101011, 1'b0, 1'b0, 1'b1);
      step(0, 6'b101011, 1'b0, 1'b0, 1'b0);
      // reset during a MEMRD wait, with MemReady high on the reset edge
      step(0, 6'b100011, 1'b1, 1'b0, 1'b0);
      step(1, 6'b100011, 1'b0, 1'b0, 1'b0);
      step(2, 6'b100011, 1'b0, 1'b0, 1'b0);
      step(3, 6'b100011, 1'b1, 1'b0, 1'b1);
      step(0, 6'b100011, 1'b0, 1'b0, 1'b0);
      run(6'b100011, 1, 2, 1'b0);
      run(6'b000000, 0, 0, 1'b0);
      step(0, 6'b000000, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      chk = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
